// File: rtl/hbf_mac_sched.sv
// Op scheduler for a single-MAC halfband decimate-by-2 stage.
// Drives sample-RAM writes, pair addresses, coefficient index and op tags.
module hbf_mac_sched #(
  parameter int M  = 3,
  parameter int AW = 4,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          valid_in,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          wr_zero,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [CW-1:0] coef_idx,
  output logic          op_first,
  output logic          op_last,
  output logic          busy,
  output logic          overrun,
  input  logic          clr_overrun
);

  localparam int DEPTH = 1 << AW;

  if (DEPTH < 4*M+2) begin : g_aw_chk
    $error("hbf_mac_sched: AW too small for 4M+2 samples");
  end
  if ((1 << CW) < M+1) begin : g_cw_chk
    $error("hbf_mac_sched: CW too small for M+1 coefficients");
  end

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] job_b_q, job_b_d;
  logic [AW-1:0] pend_b_q, pend_b_d;
  logic [CW-1:0] j_q, j_d;
  logic          phase_q, phase_d;
  logic          pend_q, pend_d;
  logic          ovr_q, ovr_d;

  logic          clearing;
  logic          run;
  logic          last;
  logic          accept;
  logic          trigger;
  logic          drop;
  logic [AW-1:0] j_ext;
  logic [AW-1:0] off_a;
  logic [AW-1:0] off_b;

  assign clearing = ~rst & (state_q == S_CLEAR);
  assign run      = ~rst & (state_q == S_RUN);
  assign last     = run & (j_q == CW'(M));
  assign in_ready = ~rst & en & (state_q != S_CLEAR);
  assign accept   = valid_in & in_ready;
  assign trigger  = accept & phase_q;
  assign drop     = trigger & pend_q;

  // Pair taps sit 2 apart; newer tap trails B by 2M-2-2j.
  assign j_ext = AW'(j_q);
  assign off_a = AW'(2*M-2) - (j_ext << 1);
  assign off_b = AW'(4*M-2) - (j_ext << 1);

  assign wr_en     = clearing | accept;
  assign wr_zero   = clearing;
  assign wr_addr   = rst      ? '0 :
                     clearing ? cnt_q : wp_q;
  assign rd_en     = run;
  assign rd_addr_a = ~run ? '0 :
                     last ? job_b_q - AW'(2*M-1) :
                            job_b_q - off_a;
  assign rd_addr_b = (run & ~last) ? job_b_q - off_b : '0;
  assign coef_idx  = run ? j_q : '0;
  assign op_first  = run & (j_q == '0);
  assign op_last   = last;
  assign busy      = ~rst & ((state_q == S_RUN) | pend_q);
  assign overrun   = ~rst & ovr_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wp_d     = wp_q;
    job_b_d  = job_b_q;
    pend_b_d = pend_b_q;
    j_d      = j_q;
    phase_d  = phase_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;

    unique case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = S_IDLE;
          wp_d    = '0;
        end
      end
      S_IDLE: begin
        if (trigger) begin
          state_d = S_RUN;
          j_d     = '0;
          job_b_d = wp_q;
        end
      end
      S_RUN: begin
        if (last) begin
          // Slot is sampled before this cycle's trigger can use it.
          if (pend_q) begin
            j_d     = '0;
            job_b_d = pend_b_q;
            pend_d  = 1'b0;
          end else if (trigger) begin
            j_d     = '0;
            job_b_d = wp_q;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          j_d = j_q + 1'b1;
          if (trigger && !pend_q) begin
            pend_d   = 1'b1;
            pend_b_d = wp_q;
          end
        end
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase

    if (accept) begin
      wp_d    = wp_q + 1'b1;
      phase_d = ~phase_q;
    end

    if (drop) begin
      ovr_d = 1'b1;
    end else if (clr_overrun) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_CLEAR;
      cnt_q    <= '0;
      wp_q     <= '0;
      job_b_q  <= '0;
      pend_b_q <= '0;
      j_q      <= '0;
      phase_q  <= 1'b0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wp_q     <= wp_d;
      job_b_q  <= job_b_d;
      pend_b_q <= pend_b_d;
      j_q      <= j_d;
      phase_q  <= phase_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
    end
  end

endmodule

// File: tb/tb_hbf_mac_sched.sv
// Scoreboard bench for hbf_mac_sched: expected ops are queued at each
// trigger and popped as rd_en ops appear.
module tb_hbf_mac_sched;

  localparam int M  = 3;
  localparam int AW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          valid_in;
  logic          clr_overrun;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_zero;
  logic          rd_en;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [CW-1:0] coef_idx;
  logic          op_first;
  logic          op_last;
  logic          busy;
  logic          overrun;

  hbf_mac_sched #(.M(M), .AW(AW), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .valid_in    (valid_in),
    .in_ready    (in_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_zero     (wr_zero),
    .rd_en       (rd_en),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .coef_idx    (coef_idx),
    .op_first    (op_first),
    .op_last     (op_last),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [CW-1:0] c;
    logic          f;
    logic          l;
  } op_t;

  op_t           q[$];
  op_t           mon_exp;
  op_t           mon_got;
  int            checks   = 0;
  int            failures = 0;
  logic [AW-1:0] m_wp;
  bit            m_phase;

  function automatic void push_job(input logic [AW-1:0] bb);
    op_t o;
    for (int j = 0; j < M; j++) begin
      o.a = bb - AW'(2*M-2-2*j);
      o.b = bb - AW'(4*M-2-2*j);
      o.c = CW'(j);
      o.f = (j == 0);
      o.l = 1'b0;
      q.push_back(o);
    end
    o.a = bb - AW'(2*M-1);
    o.b = '0;
    o.c = CW'(M);
    o.f = 1'b0;
    o.l = 1'b1;
    q.push_back(o);
  endfunction

  always @(negedge clk) begin
    if (rd_en === 1'b1) begin
      mon_got = {rd_addr_a, rd_addr_b, coef_idx, op_first, op_last};
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL op_unexpected got=%h required=none", mon_got);
      end else begin
        mon_exp = q.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL op_seq got=%h required=%h", mon_got, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit drop);
    valid_in = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, wr_en, wr_zero, wr_addr} !== {3'b110, m_wp}) begin
      failures++;
      $display("FAIL accept_write got=%b required=%b",
               {in_ready, wr_en, wr_zero, wr_addr}, {3'b110, m_wp});
    end
    if (m_phase && !drop) push_job(m_wp);
    m_wp    = m_wp + 1'b1;
    m_phase = ~m_phase;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic check_clear();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if ({wr_en, wr_zero, wr_addr, in_ready, rd_en, busy, overrun}
          !== {2'b11, 4'(i), 4'b0000}) begin
        failures++;
        $display("FAIL clear_cycle%0d got=%b required=%b", i,
                 {wr_en, wr_zero, wr_addr, in_ready, rd_en, busy, overrun},
                 {2'b11, 4'(i), 4'b0000});
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({in_ready, wr_en, rd_en} !== 3'b100) begin
      failures++;
      $display("FAIL clear_done got=%b required=100", {in_ready, wr_en, rd_en});
    end
    tick();
    m_wp    = '0;
    m_phase = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    check_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, wr_en, wr_zero, wr_addr, rd_en, rd_addr_a, rd_addr_b,
           coef_idx, op_first, op_last, busy, overrun} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got nonzero required=0", i);
      end
    end
    tick();
    rst = 1'b0;
    check_clear();
  endtask

  task automatic test_first_output();
    send(1'b0);
    tick();
    tick();
    send(1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({rd_en, busy} !== 2'b11) begin
        failures++;
        $display("FAIL first_busy k=%0d got=%b required=11", k, {rd_en, busy});
      end
      if (k == 0) begin
        checks++;
        if ({rd_addr_a, rd_addr_b, coef_idx, op_first, op_last}
            !== {4'd13, 4'd7, 2'd0, 2'b10}) begin
          failures++;
          $display("FAIL first_op0 got=%0d,%0d,%0d required=13,7,0",
                   rd_addr_a, rd_addr_b, coef_idx);
        end
      end
      if (k == 3) begin
        checks++;
        if ({rd_addr_a, coef_idx, op_last} !== {4'd12, 2'd3, 1'b1}) begin
          failures++;
          $display("FAIL first_centre got=%0d,%0d,%0d required=12,3,1",
                   rd_addr_a, coef_idx, op_last);
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({rd_en, busy} !== 2'b00) begin
      failures++;
      $display("FAIL first_end got=%b required=00", {rd_en, busy});
    end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send(1'b0);
      send(1'b0);
      tick();
      tick();
    end
    send(1'b0);
    tick();
    send(1'b0);
    @(negedge clk);
    checks++;
    if ({rd_en, op_first, rd_addr_a, rd_addr_b} !== {2'b11, 4'd11, 4'd5}) begin
      failures++;
      $display("FAIL wrap_op0 got=%b,%0d,%0d required=11,11,5",
               {rd_en, op_first}, rd_addr_a, rd_addr_b);
    end
    tick();
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({op_last, rd_addr_a, rd_addr_b} !== {1'b1, 4'd10, 4'd0}) begin
      failures++;
      $display("FAIL wrap_centre got=%b,%0d,%0d required=1,10,0",
               op_last, rd_addr_a, rd_addr_b);
    end
    tick();
    send(1'b0);
    repeat (4) tick();
  endtask

  task automatic test_overrun();
    do_reset();
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_init got=%b required=0", overrun);
    end
    tick();
    repeat (5) send(1'b0);
    send(1'b1);
    @(negedge clk);
    checks++;
    if ({rd_en, op_first, overrun, busy} !== 4'b1111) begin
      failures++;
      $display("FAIL ovr_job2 got=%b required=1111",
               {rd_en, op_first, overrun, busy});
    end
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if ({busy, overrun} !== 2'b01) begin
      failures++;
      $display("FAIL ovr_hold got=%b required=01", {busy, overrun});
    end
    tick();
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear got=%b required=0", overrun);
    end
    tick();
  endtask

  task automatic test_en_drop();
    send(1'b0);
    send(1'b0);
    en       = 1'b0;
    valid_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, wr_en, rd_en} !== 3'b001) begin
        failures++;
        $display("FAIL en_drop k=%0d got=%b required=001", k,
                 {in_ready, wr_en, rd_en});
      end
      tick();
    end
    valid_in = 1'b0;
    en       = 1'b1;
    @(negedge clk);
    checks++;
    if ({rd_en, busy} !== 2'b00) begin
      failures++;
      $display("FAIL en_idle got=%b required=00", {rd_en, busy});
    end
    tick();
    send(1'b0);
    @(negedge clk);
    checks++;
    if (rd_en !== 1'b0) begin
      failures++;
      $display("FAIL en_phase got=%b required=0", rd_en);
    end
    tick();
    send(1'b0);
    repeat (5) tick();
  endtask

  task automatic test_reset_mid();
    repeat (5) send(1'b0);
    send(1'b1);
    send(1'b0);
    send(1'b0);
    @(negedge clk);
    checks++;
    if ({rd_en, busy, overrun, coef_idx} !== {3'b111, 2'd2}) begin
      failures++;
      $display("FAIL mid_pre got=%b required=11110",
               {rd_en, busy, overrun, coef_idx});
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rd_en, op_last, busy, overrun, wr_en, in_ready} !== 6'b0) begin
      failures++;
      $display("FAIL mid_rst got=%b required=000000",
               {rd_en, op_last, busy, overrun, wr_en, in_ready});
    end
    tick();
    rst = 1'b0;
    q.delete();
    check_clear();
  endtask

  initial begin
    rst         = 1'b1;
    en          = 1'b1;
    valid_in    = 1'b0;
    clr_overrun = 1'b0;
    m_wp        = '0;
    m_phase     = 1'b0;
    test_reset();
    test_first_output();
    test_wrap();
    test_overrun();
    test_en_drop();
    test_reset_mid();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL ops_missing got=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
